// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern engine: off, blink, chase and PWM breathe modes,
// all advanced by a prescaled pattern tick derived from the PLL clock.
module led_pattern_gen #(
  parameter int NUM_LEDS = 4,
  parameter int TICK_DIV = 5_000_000,
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [1:0]          mode_i,
  output logic [NUM_LEDS-1:0] led_o,
  output logic                tick_o
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int POS_W = $clog2(NUM_LEDS);

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]    POS_ONE  = POS_W'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  mode_t               mode_q;
  dir_t                dir_q, dir_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                blink_q, blink_d;
  logic [NUM_LEDS-1:0] led_d;
  logic [NUM_LEDS-1:0] chase_vec;
  logic                mode_chg;
  logic                tick;

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chase
    assign chase_vec[gi] = (pos_q == POS_W'(gi));
  end

  always_comb begin
    pre_d    = pre_q;
    pwm_d    = pwm_q;
    blink_d  = blink_q;
    pos_d    = pos_q;
    duty_d   = duty_q;
    dir_d    = dir_q;
    led_d    = '0;
    mode_chg = (mode_i != mode_q);
    tick     = en_i && (pre_q == PRE_LAST) && !mode_chg;

    if (en_i) begin
      pwm_d = pwm_q + DUTY_ONE;
    end

    // A mode change restarts the pattern and the prescaler, even while frozen.
    if (mode_chg) begin
      pre_d   = '0;
      blink_d = 1'b0;
      pos_d   = '0;
      duty_d  = '0;
      dir_d   = DIR_UP;
    end else begin
      if (en_i) begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
      end
      if (tick) begin
        case (mode_q)
          MODE_BLINK: blink_d = ~blink_q;
          MODE_CHASE: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
          MODE_BREATHE: begin
            // Direction flips on the same tick that reaches the end stop.
            if (dir_q == DIR_UP) begin
              if (duty_q != DUTY_MAX) duty_d = duty_q + DUTY_ONE;
              if (duty_q >= DUTY_MAX - DUTY_ONE) dir_d = DIR_DOWN;
            end else begin
              if (duty_q != '0) duty_d = duty_q - DUTY_ONE;
              if (duty_q <= DUTY_ONE) dir_d = DIR_UP;
            end
          end
          default: ;
        endcase
      end
    end

    case (mode_q)
      MODE_BLINK:   led_d = {NUM_LEDS{blink_q}};
      MODE_CHASE:   led_d = chase_vec;
      MODE_BREATHE: led_d = {NUM_LEDS{pwm_q < duty_q}};
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q  <= MODE_OFF;
      pre_q   <= '0;
      pwm_q   <= '0;
      blink_q <= 1'b0;
      pos_q   <= '0;
      duty_q  <= '0;
      dir_q   <= DIR_UP;
      led_o   <= '0;
      tick_o  <= 1'b0;
    end else begin
      mode_q  <= mode_t'(mode_i);
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      blink_q <= blink_d;
      pos_q   <= pos_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      led_o   <= led_d;
      tick_o  <= tick;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised and directed bench for led_pattern_gen against a tick-count
// reference model (patterns derived from ticks elapsed since mode entry).
module tb_led_pattern_gen;
  localparam int N    = 4;
  localparam int TD   = 4;
  localparam int PB   = 3;
  localparam int PMAX = (1 << PB) - 1;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         en_i = 1'b0;
  logic [1:0]   mode_i = 2'd0;
  logic [N-1:0] led_o;
  logic         tick_o;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Reference model state
  int m_mode  = 0;
  int m_pre   = 0;   // enabled cycles since last prescaler restart, mod TD
  int m_ticks = 0;   // pattern ticks since mode entry
  int m_pwm   = 0;
  logic [N-1:0] m_led = '0;
  logic         m_tick = 1'b0;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_LEDS(N), .TICK_DIV(TD), .PWM_BITS(PB)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .en_i  (en_i),
    .mode_i(mode_i),
    .led_o (led_o),
    .tick_o(tick_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Breathe duty is a triangle wave over the tick count: 0..PMAX..0..
  function automatic int tri_duty(input int k);
    int p;
    p = k % (2 * PMAX);
    return (p <= PMAX) ? p : 2 * PMAX - p;
  endfunction

  function automatic logic [N-1:0] pattern();
    logic [N-1:0] r;
    r = '0;
    case (m_mode)
      1: r = (m_ticks % 2 == 1) ? '1 : '0;
      2: r = N'(1) << (m_ticks % N);
      3: r = (m_pwm < tri_duty(m_ticks)) ? '1 : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_update(input logic r, input logic e, input logic [1:0] m);
    bit chg;
    if (r) begin
      m_mode = 0; m_pre = 0; m_ticks = 0; m_pwm = 0;
      m_led = '0; m_tick = 1'b0;
    end else begin
      chg    = (int'(m) != m_mode);
      m_led  = pattern();
      m_tick = e && !chg && (m_pre == TD - 1);
      if (e) m_pwm = (m_pwm + 1) % (PMAX + 1);
      if (chg) begin
        m_pre = 0;
        m_ticks = 0;
      end else if (e) begin
        if (m_tick) m_ticks++;
        m_pre = (m_pre + 1) % TD;
      end
      m_mode = int'(m);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m);
    rst_i = r; en_i = e; mode_i = m;
    @(posedge clk);
    model_update(r, e, m);
    #1;
    check({phase, ".led"}, 32'(led_o), 32'(m_led));
    check({phase, ".tick"}, 32'(tick_o), 32'(m_tick));
  endtask

  task automatic report();
    $display("phase %s: checks=%0d errors=%0d", phase, checks, errors);
  endtask

  initial begin
    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 2'd1);
    report();

    phase = "blink";
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 2'd1);
    report();

    phase = "chase";
    for (int i = 0; i < 6 * TD + 2; i++) step(1'b0, 1'b1, 2'd2);
    report();

    phase = "breathe";
    for (int i = 0; i < 20 * TD + 2; i++) step(1'b0, 1'b1, 2'd3);
    report();

    phase = "freeze";
    step(1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 50 && m_ticks != 2; i++) step(1'b0, 1'b1, 2'd2);
    check("freeze.reach_pos2", 32'(m_ticks), 32'd2);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 2'd2);
      check("freeze.hold", 32'(led_o), 32'h4);
      check("freeze.notick", 32'(tick_o), 32'd0);
    end
    phase = "switch";
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 2'd1);
    report();

    phase = "midreset";
    step(1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 200 && (m_ticks % (2 * PMAX)) != 9; i++) step(1'b0, 1'b1, 2'd3);
    check("midreset.reach_duty5_down", 32'(tri_duty(m_ticks)), 32'd5);
    step(1'b1, 1'b1, 2'd3);
    check("midreset.led_zero", 32'(led_o), 32'd0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 2'd3);
    report();

    phase = "random";
    begin
      logic [1:0] m;
      logic e, r;
      m = 2'd0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 19) == 0) m = 2'($urandom_range(0, 3));
        e = ($urandom_range(0, 4) != 0);
        r = ($urandom_range(0, 99) == 0);
        step(r, e, m);
      end
    end
    report();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
